// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM generator and the duty-ramp sequencer.
package pwm_pkg;

  localparam int PWM_DUTY_W = 6;
  localparam int PWM_PERIOD = 32;
  localparam int PWM_RATE_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    UP,
    DOWN
  } ramp_state_t;

endpackage

// File: rtl/pwm_duty_ramp_if.sv
// Command channel of the duty-ramp sequencer: target/rate/mode with valid/ready.
interface pwm_duty_ramp_if
  import pwm_pkg::*;
#(
  parameter int DUTY_W = PWM_DUTY_W,
  parameter int RATE_W = PWM_RATE_W
);

  logic [DUTY_W-1:0] cmd_target;
  logic [RATE_W-1:0] cmd_rate;
  logic              cmd_breathe;
  logic              cmd_valid;
  logic              cmd_ready;

  modport master (
    output cmd_target, cmd_rate, cmd_breathe, cmd_valid,
    input  cmd_ready
  );

  modport slave (
    input  cmd_target, cmd_rate, cmd_breathe, cmd_valid,
    output cmd_ready
  );

endinterface

// File: rtl/pwm_period_timer.sv
// PWM period counter plus the rate prescaler that decides which period ends fire a step.
module pwm_period_timer
  import pwm_pkg::*;
#(
  parameter int PERIOD = PWM_PERIOD,
  parameter int RATE_W = PWM_RATE_W
) (
  input  logic              clk_in,
  input  logic              rst,
  input  logic [RATE_W-1:0] rate,
  input  logic              rate_clr,
  output logic              period_tick,
  output logic              step_en
);

  localparam int CNT_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD - 1);

  logic [CNT_W-1:0]  count_reg;
  logic [RATE_W-1:0] rate_cnt_reg;

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      count_reg    <= '0;
      rate_cnt_reg <= '0;
    end else begin
      count_reg <= (count_reg == LAST) ? '0 : count_reg + 1'b1;
      // A freshly accepted command restarts the prescaler, even on a tick.
      if (rate_clr) begin
        rate_cnt_reg <= '0;
      end else if (period_tick) begin
        rate_cnt_reg <= (rate_cnt_reg == rate) ? '0 : rate_cnt_reg + 1'b1;
      end
    end
  end

  assign period_tick = (count_reg == LAST);
  assign step_en     = period_tick && (rate_cnt_reg == rate) && !rate_clr;

endmodule

// File: rtl/pwm_duty_ramp.sv
// Steps a registered PWM duty toward a target (one-shot) or sweeps 0..target (breathe),
// changing duty only on PWM period boundaries.
module pwm_duty_ramp
  import pwm_pkg::*;
#(
  parameter int DUTY_W = PWM_DUTY_W,
  parameter int PERIOD = PWM_PERIOD,
  parameter int RATE_W = PWM_RATE_W
) (
  input  logic              clk_in,
  input  logic              rst,
  pwm_duty_ramp_if.slave    cmd,
  output logic [DUTY_W-1:0] duty_out,
  output logic              period_tick,
  output logic              busy
);

  localparam logic [DUTY_W-1:0] DUTY_MAX = DUTY_W'(PERIOD);

  ramp_state_t       state_reg, state_next;
  logic [DUTY_W-1:0] duty_reg, duty_next;
  logic [DUTY_W-1:0] tgt_reg, tgt_next;
  logic [RATE_W-1:0] rate_reg, rate_next;
  logic              breathe_reg, breathe_next;

  logic              accept;
  logic              step_en;
  logic [DUTY_W-1:0] tgt_in;
  logic [DUTY_W-1:0] duty_inc;
  logic [DUTY_W-1:0] duty_dec;

  assign cmd.cmd_ready = (state_reg == IDLE) || breathe_reg;
  assign accept        = cmd.cmd_valid && cmd.cmd_ready;
  // Anything at or above PERIOD is already 100 % duty.
  assign tgt_in        = (cmd.cmd_target > DUTY_MAX) ? DUTY_MAX : cmd.cmd_target;
  assign duty_inc      = duty_reg + 1'b1;
  assign duty_dec      = duty_reg - 1'b1;

  pwm_period_timer #(
    .PERIOD (PERIOD),
    .RATE_W (RATE_W)
  ) u_timer (
    .clk_in      (clk_in),
    .rst         (rst),
    .rate        (rate_reg),
    .rate_clr    (accept),
    .period_tick (period_tick),
    .step_en     (step_en)
  );

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      duty_reg    <= '0;
      tgt_reg     <= '0;
      rate_reg    <= '0;
      breathe_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      duty_reg    <= duty_next;
      tgt_reg     <= tgt_next;
      rate_reg    <= rate_next;
      breathe_reg <= breathe_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    duty_next    = duty_reg;
    tgt_next     = tgt_reg;
    rate_next    = rate_reg;
    breathe_next = breathe_reg;

    if (accept) begin
      tgt_next     = tgt_in;
      rate_next    = cmd.cmd_rate;
      breathe_next = cmd.cmd_breathe;
      // Breathe at/below current duty heads down first; a zero peak parks at 0.
      if (cmd.cmd_breathe) begin
        if (tgt_in == '0)            state_next = IDLE;
        else if (tgt_in > duty_reg)  state_next = UP;
        else                         state_next = DOWN;
      end else begin
        if (tgt_in > duty_reg)       state_next = UP;
        else if (tgt_in < duty_reg)  state_next = DOWN;
        else                         state_next = IDLE;
      end
    end else if (step_en) begin
      case (state_reg)
        IDLE: begin
          if (breathe_reg && (tgt_reg == '0)) duty_next = '0;
        end
        UP: begin
          if (duty_reg < tgt_reg) begin
            duty_next = duty_inc;
            if (duty_inc == tgt_reg) state_next = breathe_reg ? DOWN : IDLE;
          end else begin
            state_next = breathe_reg ? DOWN : IDLE;
          end
        end
        DOWN: begin
          if (breathe_reg) begin
            if (duty_reg != '0) begin
              duty_next = duty_dec;
              if (duty_dec == '0) state_next = UP;
            end else begin
              state_next = UP;
            end
          end else if (duty_reg > tgt_reg) begin
            duty_next = duty_dec;
            if (duty_dec == tgt_reg) state_next = IDLE;
          end else begin
            state_next = IDLE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  assign duty_out = duty_reg;
  assign busy     = (state_reg != IDLE);

endmodule

// File: tb/tb_pwm_duty_ramp.sv
// Scoreboard bench for pwm_duty_ramp: expected per-period duties are queued when a
// command is sent and compared at the start of each following PWM period.
module tb_pwm_duty_ramp;
  import pwm_pkg::*;

  logic clk_in = 1'b0;
  logic rst    = 1'b1;
  always #5 clk_in = ~clk_in;

  pwm_duty_ramp_if cmd_bus ();

  logic [PWM_DUTY_W-1:0] duty_out;
  logic                  period_tick;
  logic                  busy;

  pwm_duty_ramp dut (
    .clk_in      (clk_in),
    .rst         (rst),
    .cmd         (cmd_bus),
    .duty_out    (duty_out),
    .period_tick (period_tick),
    .busy        (busy)
  );

  int checks = 0;
  int errors = 0;
  int sb[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s = %0d", tag, got);
    end
  endtask

  // Returns at the negedge of cycle 0 of the period following the next tick.
  task automatic wait_tick();
    int n = 0;
    while (period_tick !== 1'b1 && n < 40) begin
      @(negedge clk_in);
      n++;
    end
    if (n >= 40) check("tick_timeout", 32'd0, 32'd1);
    @(posedge clk_in);
    @(negedge clk_in);
  endtask

  task automatic step_check(input string tag);
    wait_tick();
    if (sb.size() == 0) check("scoreboard_empty", 32'd0, 32'd1);
    else check(tag, 32'(duty_out), 32'(sb.pop_front()));
  endtask

  task automatic send(input int tgt, input int rate, input logic br);
    int n = 0;
    cmd_bus.cmd_target  = PWM_DUTY_W'(tgt);
    cmd_bus.cmd_rate    = PWM_RATE_W'(rate);
    cmd_bus.cmd_breathe = br;
    cmd_bus.cmd_valid   = 1'b1;
    while (cmd_bus.cmd_ready !== 1'b1 && n < 2000) begin
      @(negedge clk_in);
      n++;
    end
    if (n >= 2000) check("ready_timeout", 32'd0, 32'd1);
    @(posedge clk_in);
    @(negedge clk_in);
    cmd_bus.cmd_valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    cmd_bus.cmd_target  = '0;
    cmd_bus.cmd_rate    = '0;
    cmd_bus.cmd_breathe = 1'b0;
    cmd_bus.cmd_valid   = 1'b0;

    // Handshake offered during reset must be ignored.
    repeat (2) @(negedge clk_in);
    cmd_bus.cmd_target = 6'd5;
    cmd_bus.cmd_valid  = 1'b1;
    repeat (3) @(negedge clk_in);
    cmd_bus.cmd_valid  = 1'b0;
    rst = 1'b0;
    check("reset_duty", 32'(duty_out), 32'd0);
    check("reset_ready", 32'(cmd_bus.cmd_ready), 32'd1);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_tick", 32'(period_tick), 32'd0);

    n = 0;
    while (period_tick !== 1'b1 && n < 100) begin
      @(negedge clk_in);
      n++;
    end
    check("first_tick_cycle", 32'(n), 32'd31);
    n = 0;
    do begin
      @(negedge clk_in);
      n++;
    end while (period_tick !== 1'b1 && n < 100);
    check("tick_spacing", 32'(n), 32'd32);
    check("idle_duty", 32'(duty_out), 32'd0);

    // One-shot ramp 0 -> 10 at one step per period.
    send(10, 0, 1'b0);
    check("up_busy", 32'(busy), 32'd1);
    check("up_ready", 32'(cmd_bus.cmd_ready), 32'd0);
    for (int v = 1; v <= 10; v++) sb.push_back(v);
    for (int i = 1; i <= 10; i++) begin
      step_check("ramp_up");
      check("ramp_up_ready", 32'(cmd_bus.cmd_ready), 32'(i == 10));
    end
    check("up_done_busy", 32'(busy), 32'd0);

    // Ramp down 10 -> 4, rate 2; a second command is held valid throughout.
    send(4, 2, 1'b0);
    cmd_bus.cmd_target  = 6'd6;
    cmd_bus.cmd_rate    = 8'd0;
    cmd_bus.cmd_breathe = 1'b0;
    cmd_bus.cmd_valid   = 1'b1;
    for (int t = 1; t <= 18; t++) sb.push_back(10 - t / 3);
    for (int t = 1; t <= 18; t++) begin
      step_check("ramp_down");
      check("held_ready", 32'(cmd_bus.cmd_ready), 32'(t == 18));
    end
    @(posedge clk_in);
    @(negedge clk_in);
    cmd_bus.cmd_valid = 1'b0;
    check("held_accepted_busy", 32'(busy), 32'd1);
    sb.push_back(5);
    sb.push_back(6);
    step_check("held_ramp");
    step_check("held_ramp");
    check("held_done_busy", 32'(busy), 32'd0);

    // Target above PERIOD clamps to 32.
    send(50, 0, 1'b0);
    for (int v = 7; v <= 32; v++) sb.push_back(v);
    sb.push_back(32);
    for (int i = 0; i < 27; i++) step_check("clamp");
    check("clamp_busy", 32'(busy), 32'd0);

    // Reset asserted mid-ramp at duty 7.
    send(0, 0, 1'b0);
    for (int v = 31; v >= 7; v--) sb.push_back(v);
    for (int i = 0; i < 25; i++) step_check("ramp_to_7");
    repeat (3) @(negedge clk_in);
    #2 rst = 1'b1;
    #1;
    check("async_rst_duty", 32'(duty_out), 32'd0);
    check("async_rst_busy", 32'(busy), 32'd0);
    check("async_rst_ready", 32'(cmd_bus.cmd_ready), 32'd1);
    @(negedge clk_in);
    rst = 1'b0;

    // Breathe to peak 3, then retarget the peak to 1 while at 3.
    send(3, 0, 1'b1);
    check("breathe_ready", 32'(cmd_bus.cmd_ready), 32'd1);
    sb = '{1, 2, 3, 2, 1, 0, 1, 2, 3};
    for (int i = 0; i < 9; i++) step_check("breathe3");
    send(1, 0, 1'b1);
    sb = '{2, 1, 0, 1, 0, 1};
    for (int i = 0; i < 6; i++) step_check("breathe1");
    check("breathe_busy", 32'(busy), 32'd1);

    // Command accepted on a step tick: no step that period, counter restarts.
    n = 0;
    while (period_tick !== 1'b1 && n < 40) begin
      @(negedge clk_in);
      n++;
    end
    if (n >= 40) check("tick_timeout", 32'd0, 32'd1);
    cmd_bus.cmd_target  = 6'd3;
    cmd_bus.cmd_rate    = 8'd0;
    cmd_bus.cmd_breathe = 1'b1;
    cmd_bus.cmd_valid   = 1'b1;
    @(posedge clk_in);
    @(negedge clk_in);
    cmd_bus.cmd_valid = 1'b0;
    sb.push_back(1);
    check("accept_on_tick", 32'(duty_out), 32'(sb.pop_front()));
    sb = '{2, 3, 2};
    for (int i = 0; i < 3; i++) step_check("retarget_on_tick");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
